// File: rtl/riscv_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes and byte-enable base masks.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path of the LSU: store lane steering, byte-enable generation,
// alignment/funct3 legality check, and load lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_err,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_err   = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'(BE_BYTE << i_addr_lo);
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be    = 4'(BE_HALF << i_addr_lo);
        o_wdata = {2{i_store_data[15:0]}};
        o_err   = i_addr_lo[0];
      end
      F3_W: begin
        o_be    = BE_WORD;
        o_wdata = i_store_data;
        o_err   = (i_addr_lo != 2'b00);
      end
      default: o_err = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (i_is_store && i_funct3[2]) o_err = 1'b1;
  end

  assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
      F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one op from EX, runs a single valid/ready
// transaction to data memory, stalls upstream while busy and returns load data to writeback.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        lsu_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       r_state;
  logic             r_busy;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_misalign_err;
  logic             r_bus_err;
  logic             r_req_valid;
  logic [31:0]      r_mem_addr;
  logic             r_mem_we;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_wdata;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_err;
  logic [31:0]      w_ld_data;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;

  lsu_align u_align (
    .i_funct3     (ex_funct3),
    .i_addr_lo    (ex_addr[1:0]),
    .i_is_store   (ex_is_store),
    .i_store_data (ex_store_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_err        (w_err),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rsp_rdata),
    .o_ld_data    (w_ld_data)
  );

  assign w_accept   = (r_state == IDLE) && ex_valid && (ex_is_load || ex_is_store);
  assign w_cnt_next = r_cnt + CNT_W'(1);
  // A zero TIMEOUT_CYCLES lets the counter wrap harmlessly and never fires.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      r_req_valid    <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_be       <= '0;
      r_mem_wdata    <= '0;
      r_funct3       <= '0;
      r_addr_lo      <= '0;
      r_rd           <= '0;
      r_cnt          <= '0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_misalign_err <= 1'b1;
            end else begin
              r_state     <= REQ;
              r_busy      <= 1'b1;
              r_req_valid <= 1'b1;
              r_mem_addr  <= {ex_addr[31:2], 2'b00};
              r_mem_we    <= ex_is_store;
              r_mem_be    <= w_be;
              r_mem_wdata <= ex_is_store ? w_wdata : '0;
              r_funct3    <= ex_funct3;
              r_addr_lo   <= ex_addr[1:0];
              r_rd        <= ex_rd;
              r_cnt       <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            if (r_mem_we) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RESP;
            end
          end else if (w_timeout) begin
            r_req_valid <= 1'b0;
            r_bus_err   <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        RESP: begin
          if (mem_rsp_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_ld_data;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_busy      = r_busy;
  assign wb_valid      = r_wb_valid;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign misalign_err  = r_misalign_err;
  assign bus_err       = r_bus_err;
  assign mem_req_valid = r_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_busy, wb_valid, misalign_err, bus_err, mem_req_valid, mem_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .lsu_busy(lsu_busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_REQ, EV_WB, EV_MIS, EV_BUS} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [31:0] a, input logic we,
                                  input logic [3:0] be, input logic [31:0] wd,
                                  input logic [4:0] rd, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_ev(input ev_kind_t k, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: EV_REQ, addr: '0, we: 1'b0, be: '0, wdata: '0, rd: '0, data: '0};
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      ok = (e.kind == k);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  logic prev_req = 1'b0;
  ev_t  cur_req;
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req_valid) begin
        if (!prev_req) begin
          pop_ev(EV_REQ, e, ok);
          if (ok) begin
            cur_req = e;
            check("req_addr", mem_addr, e.addr);
            check("req_we", 32'(mem_we), 32'(e.we));
            check("req_be", 32'(mem_be), 32'(e.be));
            if (e.we) check("req_wdata", mem_wdata, e.wdata);
          end
        end else begin
          check("req_stable_addr", mem_addr, cur_req.addr);
          check("req_stable_be", 32'(mem_be), 32'(cur_req.be));
        end
      end
      prev_req = mem_req_valid;
      if (wb_valid) begin
        pop_ev(EV_WB, e, ok);
        if (ok) begin
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
        end
      end
      if (misalign_err) pop_ev(EV_MIS, e, ok);
      if (bus_err) pop_ev(EV_BUS, e, ok);
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_store_data = sd; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic wait_req();
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                          input logic [3:0] be, input logic [31:0] wd);
    push_ev(EV_REQ, {a[31:2], 2'b00}, 1'b1, be, wd, '0, '0);
    mem_req_ready = 1'b1;
    issue(1'b0, 1'b1, f3, a, sd, 5'd0);
    @(negedge clk);
    check("st_busy_req", 32'(lsu_busy), 32'd1);
    @(negedge clk);
    check("st_busy_done", 32'(lsu_busy), 32'd0);
    check("st_req_dropped", 32'(mem_req_valid), 32'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [3:0] be, input logic [31:0] word, input logic [31:0] exp_d);
    push_ev(EV_REQ, {a[31:2], 2'b00}, 1'b0, be, '0, '0, '0);
    push_ev(EV_WB, '0, 1'b0, '0, '0, rd, exp_d);
    mem_req_ready = 1'b1;
    issue(1'b1, 1'b0, f3, a, 32'hA5A5_A5A5, rd);
    wait_req();
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = word;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("ld_wb_seen", 32'(wb_valid), 32'd1);
    check("ld_busy_done", 32'(lsu_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_err(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
    push_ev(EV_MIS, '0, 1'b0, '0, '0, '0, '0);
    mem_req_ready = 1'b1;
    issue(ld, st, f3, a, 32'h1234_5678, 5'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_no_busy", 32'(lsu_busy), 32'd0);
      check("err_no_req", 32'(mem_req_valid), 32'd0);
    end
  endtask

  initial begin
    int n_wait;
    bit seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs_zero",
          32'(|{lsu_busy, wb_valid, wb_rd, wb_data, misalign_err, bus_err, mem_req_valid,
                mem_addr, mem_we, mem_be, mem_wdata}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(lsu_busy), 32'd0);

    // 1: SW
    do_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    // 2: LB / LBU on top byte
    do_load(3'b000, 32'h0000_0203, 5'd5, 4'b1000, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_0203, 5'd6, 4'b1000, 32'h80FF_0000, 32'h0000_0080);
    // 3: LH / LHU upper half, SH upper half, SB lane 1
    do_load(3'b001, 32'h0000_0102, 5'd10, 4'b1100, 32'h8001_1234, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_0102, 5'd11, 4'b1100, 32'h8001_1234, 32'h0000_8001);
    do_store(3'b001, 32'h0000_0102, 32'h0000_5A5A, 4'b1100, 32'h5A5A_5A5A);
    do_store(3'b000, 32'h0000_0101, 32'hFFFF_FF12, 4'b0010, 32'h1212_1212);
    do_load(3'b010, 32'h0000_0400, 5'd31, 4'b1111, 32'h0123_4567, 32'h0123_4567);
    // 4: misaligned and illegal encodings
    do_err(1'b1, 1'b0, 3'b010, 32'h0000_0101);
    do_err(1'b1, 1'b0, 3'b001, 32'h0000_0103);
    do_err(1'b1, 1'b0, 3'b011, 32'h0000_0100);
    do_err(1'b0, 1'b1, 3'b100, 32'h0000_0100);

    // 5: timeout with ready held low
    push_ev(EV_REQ, 32'h0000_0200, 1'b0, 4'b1111, '0, '0, '0);
    push_ev(EV_BUS, '0, 1'b0, '0, '0, '0, '0);
    mem_req_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, '0, 5'd3);
    n_wait = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_err) begin
        seen = 1'b1;
        break;
      end
      if (mem_req_valid) n_wait++;
    end
    check("to_bus_err_seen", 32'(seen), 32'd1);
    check("to_wait_cycles", 32'(n_wait), 32'd8);
    check("to_idle", 32'(lsu_busy), 32'd0);
    check("to_req_dropped", 32'(mem_req_valid), 32'd0);
    do_store(3'b010, 32'h0000_0204, 32'h1122_3344, 4'b1111, 32'h1122_3344);

    // 6: reset while in RESP, late response must be ignored
    push_ev(EV_REQ, 32'h0000_0300, 1'b0, 4'b1111, '0, '0, '0);
    mem_req_ready = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, '0, 5'd7);
    wait_req();
    @(negedge clk);
    check("resp_busy", 32'(lsu_busy), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_abandon_zero",
            32'(|{lsu_busy, wb_valid, wb_rd, wb_data, misalign_err, bus_err, mem_req_valid,
                  mem_addr, mem_we, mem_be, mem_wdata}), 32'd0);
    end
    do_load(3'b101, 32'h0000_0102, 5'd12, 4'b1100, 32'h8001_1234, 32'h0000_8001);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
